fixed_point_add_arbiter: RTL

Round-robin arbiter that shares one registered fixed-point adder among NUM_REQ requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants one requester per cycle and computes A+B in the shared add stage. It returns the sum tagged with the requester index over a valid/ready result port with backpressure. It sits between the neuron/accumulator lanes and the single adder resource when area forbids one adder per lane.

---
 rtl/fixed_point_add_arbiter.sv | 80 ++++++++
 1 files changed

// File: rtl/fixed_point_add_arbiter.sv
// fixed_point_add_arbiter: round-robin share of one registered fixed-point adder among NUM_REQ requesters.
// Sum is tagged with the winning index and held in a single result register with valid/ready backpressure.
module fixed_point_add_arbiter #(
   parameter int WIDTH     = 8,
   parameter int FRAC_BITS = 3,
   parameter int NUM_REQ   = 4,
   parameter int SATURATE  = 0
)(
   input  logic                       CLK,
   input  logic                       RSTN,
   input  logic [NUM_REQ-1:0]         REQ_VALID_IN,
   input  logic [NUM_REQ*WIDTH-1:0]   REQ_A_IN,
   input  logic [NUM_REQ*WIDTH-1:0]   REQ_B_IN,
   output logic [NUM_REQ-1:0]         REQ_READY_OUT,
   output logic [WIDTH-1:0]           RESULT_OUT,
   output logic [$clog2(NUM_REQ)-1:0] RESULT_ID_OUT,
   output logic                       RESULT_OVF_OUT,
   output logic                       RESULT_VALID_OUT,
   input  logic                       RESULT_READY_IN
);
   localparam int ID_W = $clog2(NUM_REQ);
   // Binary point is shared by inputs and output; illegal configurations never grant.
   localparam logic CFG_OK = (FRAC_BITS > 0) && (NUM_REQ >= 2);

   logic [ID_W-1:0]  r_ptr, r_id;
   logic [WIDTH-1:0] r_res;
   logic             r_ovf, r_valid;
   logic [ID_W-1:0]  w_cand, w_win, w_next;
   logic             w_found, w_can_issue, w_fire, w_ovf;
   logic [WIDTH-1:0] w_a, w_b, w_res;
   logic [WIDTH:0]   w_sum;

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
         if (!w_found && REQ_VALID_IN[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   assign w_can_issue   = RSTN && CFG_OK && (!r_valid || RESULT_READY_IN);
   assign w_fire        = w_can_issue && w_found;
   assign REQ_READY_OUT = w_fire ? NUM_REQ'(1) << w_win : '0;
   assign w_next        = ID_W'((int'(w_win) + 1) % NUM_REQ);

   assign w_a   = REQ_A_IN[int'(w_win)*WIDTH +: WIDTH];
   assign w_b   = REQ_B_IN[int'(w_win)*WIDTH +: WIDTH];
   assign w_sum = {w_a[WIDTH-1], w_a} + {w_b[WIDTH-1], w_b};
   assign w_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
   // Overflow implies both operands share a sign, so A's sign picks the clamp rail.
   assign w_res = (SATURATE != 0 && w_ovf) ? {w_a[WIDTH-1], {(WIDTH-1){~w_a[WIDTH-1]}}} : w_sum[WIDTH-1:0];

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         r_valid <= 1'b0;
         r_res   <= '0;
         r_id    <= '0;
         r_ovf   <= 1'b0;
         r_ptr   <= '0;
      end else if (w_fire) begin
         r_valid <= 1'b1;
         r_res   <= w_res;
         r_id    <= w_win;
         r_ovf   <= w_ovf;
         r_ptr   <= w_next;
      end else if (RESULT_READY_IN) begin
         r_valid <= 1'b0;
      end
   end

   assign RESULT_OUT       = r_res;
   assign RESULT_ID_OUT    = r_id;
   assign RESULT_OVF_OUT   = r_ovf;
   assign RESULT_VALID_OUT = r_valid;
endmodule
